// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage feeding decode. Owns the PC, issues one request at
// a time to instruction memory (req/gnt/rvalid), latches the returned word in
// an instruction register and offers it to decode with a valid/ready
// handshake. Execute can redirect the PC; in-flight fetches are squashed and
// a misaligned redirect target parks the unit in HALT with a sticky fault.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   imem_req/imem_addr    fetch request and word-aligned address (registered)
//   imem_gnt              memory accepted the request this cycle
//   imem_rvalid/rdata     returned instruction word
//   redirect_valid/pc     branch/jump target from execute
//   instr_valid/ready     handshake towards decode
//   instr, instr_pc       instruction register and its PC
//   instr_pc_plus4        link address for JAL
//   opcode/func3/func7    field slices of instr
//   fetch_fault           sticky misaligned-redirect flag
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned                 ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]       RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] instr_pc_plus4,
  output logic [6:0]            opcode,
  output logic [2:0]            func3,
  output logic [6:0]            func7,
  output logic                  fetch_fault
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(32'd4);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_VALID = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e                state_q, state_d, state_nrm;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_WIDTH-1:0] instr_pc_plus4_q, instr_pc_plus4_d;
  logic                  fault_q, fault_d;
  logic                  imem_req_q, imem_req_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  gnt_accept;
  logic                  rvalid_pending;

  // Next-state, PC and instruction-register logic, redirect overriding the normal flow
  always_comb begin
    state_nrm        = state_q;
    state_d          = state_q;
    pc_d             = pc_q;
    instr_d          = instr_q;
    instr_pc_d       = instr_pc_q;
    instr_pc_plus4_d = instr_pc_plus4_q;
    fault_d          = fault_q;
    // A grant only counts while our request is actually on the bus; this
    // also keeps the post-reset bubble cycle from being granted.
    gnt_accept       = imem_gnt & imem_req_q;
    rvalid_pending   = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (gnt_accept) begin
          state_nrm = S_WAIT;
        end else begin
          state_nrm = S_FETCH;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d          = imem_rdata;
          instr_pc_d       = pc_q;
          instr_pc_plus4_d = pc_q + PC_STEP;
          state_nrm        = S_VALID;
        end else begin
          state_nrm = S_WAIT;
        end
      end
      S_VALID: begin
        if (instr_ready) begin
          pc_d      = pc_q + PC_STEP;
          state_nrm = S_FETCH;
        end else begin
          state_nrm = S_VALID;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
          state_nrm = S_FETCH;
        end else begin
          state_nrm = S_DRAIN;
        end
      end
      S_HALT: begin
        state_nrm = S_HALT;
      end
      default: begin
        state_nrm = S_FETCH;
      end
    endcase

    // A request is still in flight after this edge if it is granted now, or
    // if we are waiting/draining and its data does not arrive this cycle.
    if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_rvalid) begin
      rvalid_pending = 1'b1;
    end else if ((state_q == S_FETCH) && gnt_accept) begin
      rvalid_pending = 1'b1;
    end else begin
      rvalid_pending = 1'b0;
    end

    if (redirect_valid && (state_q != S_HALT)) begin
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d             = redirect_pc;
        // Drop any word captured this cycle: it belongs to the old path.
        instr_d          = instr_q;
        instr_pc_d       = instr_pc_q;
        instr_pc_plus4_d = instr_pc_plus4_q;
        if (rvalid_pending) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_FETCH;
        end
      end else begin
        pc_d             = pc_q;
        instr_d          = instr_q;
        instr_pc_d       = instr_pc_q;
        instr_pc_plus4_d = instr_pc_plus4_q;
        fault_d          = 1'b1;
        state_d          = S_HALT;
      end
    end else begin
      state_d = state_nrm;
    end

    // Bus/handshake outputs are registered from the next state so that
    // instr_ready never reaches imem_req combinationally.
    imem_req_d    = (state_d == S_FETCH);
    instr_valid_d = (state_d == S_VALID);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_FETCH;
      pc_q             <= RESET_PC;
      instr_q          <= 32'h0000_0000;
      instr_pc_q       <= {ADDR_WIDTH{1'b0}};
      instr_pc_plus4_q <= {ADDR_WIDTH{1'b0}};
      fault_q          <= 1'b0;
      imem_req_q       <= 1'b0;
      instr_valid_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      instr_q          <= instr_d;
      instr_pc_q       <= instr_pc_d;
      instr_pc_plus4_q <= instr_pc_plus4_d;
      fault_q          <= fault_d;
      imem_req_q       <= imem_req_d;
      instr_valid_q    <= instr_valid_d;
    end
  end

  assign imem_req       = imem_req_q;
  assign imem_addr      = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_pc_plus4 = instr_pc_plus4_q;
  assign opcode         = instr_q[6:0];
  assign func3          = instr_q[14:12];
  assign func7          = instr_q[31:25];
  assign fetch_fault    = fault_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the decode/controller stage.
- Owns the PC and issues one-at-a-time requests to instruction memory over a req/gnt/rvalid handshake.
- Holds the fetched word in an instruction register and presents it, already split into opcode/func3/func7, with a valid/ready handshake to decode.
- Accepts branch/jump redirects from execute, squashes in-flight fetches and flags misaligned targets.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
ADDR_WIDTH, 32, width of PC and imem address.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request
imem_addr  out  ADDR_WIDTH  word-aligned fetch address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  instruction word
redirect_valid  in  1  branch taken / jump from execute
redirect_pc  in  ADDR_WIDTH  redirect target
instr_valid  out  1  instruction register valid
instr_ready  in  1  decode accepts instruction
instr  out  32  instruction word
instr_pc  out  ADDR_WIDTH  PC of instr
instr_pc_plus4  out  ADDR_WIDTH  instr_pc + 4, for JAL link
opcode  out  7  instr[6:0]
func3  out  3  instr[14:12]
func7  out  7  instr[31:25]
fetch_fault  out  1  sticky misaligned-redirect flag

Behaviour:
- Reset (rst_n=0 at clk edge):
  - pc<=RESET_PC; state<=FETCH.
  - imem_req=0, instr_valid=0, fetch_fault=0; instr/instr_pc/instr_pc_plus4=0.
  - First imem_req is asserted in the first cycle after rst_n=1 is sampled.
  - Reset mid-operation drops any outstanding request; a later stray rvalid is ignored.
- States:
  - FETCH: imem_req=1, imem_addr=pc. Addr is held stable until gnt. On gnt -> WAIT.
  - WAIT: imem_req=0. On rvalid: instr<=rdata, instr_pc<=pc, instr_valid<=1 -> VALID.
  - VALID: instr_valid=1; outputs held stable. On instr_ready: pc<=pc+4 (mod 2^ADDR_WIDTH, wraps), instr_valid<=0 -> FETCH. imem_req rises the cycle after the handshake (no combinational ready->req path).
  - DRAIN: one squashed request is still outstanding. imem_req=0. The next rvalid is discarded -> FETCH.
  - HALT: entered on misaligned redirect. imem_req=0, instr_valid=0 until reset.
- Exactly one outstanding request at a time. rvalid arrives at least 1 cycle after gnt. rvalid outside WAIT/DRAIN is ignored.
- Redirect handling (redirect_valid=1 at an edge) overrides normal transitions:
  - Aligned target (redirect_pc[1:0]==0): pc<=redirect_pc; instr_valid<=0.
    - If in WAIT, or in FETCH with gnt in the same cycle: -> DRAIN.
    - Otherwise: -> FETCH.
  - Misaligned target: fetch_fault<=1; -> HALT.
  - Redirect in VALID with instr_ready=1: the handshake still counts as accepted, but the redirect target wins over pc+4.
  - Redirect in WAIT with rvalid the same cycle: the data is discarded and the request is complete -> FETCH (not DRAIN).
  - Redirect in DRAIN: update pc and stay in DRAIN.
- Output combinational relations:
  - opcode/func3/func7 are slices of the instr register.
  - instr_pc_plus4 = instr_pc + 4, truncated to ADDR_WIDTH.
- Latency: with gnt the same cycle as req and rvalid the cycle after, instr_valid rises 2 cycles after req is asserted. Back-to-back throughput is one instruction per 3 cycles with instr_ready held high.

Test Plan:
- Reset release, gnt tied high, rvalid 1 cycle after gnt, rdata=32'h00500093 (addi x1,x0,5), instr_ready=1 -> imem_addr=0; instr_valid with opcode=7'b0010011, func3=0, instr_pc=0, instr_pc_plus4=4; next imem_addr=4.
- Backpressure: instr_ready=0 for 5 cycles in VALID -> instr_valid and instr held stable, imem_req=0; instr_ready=1 -> next fetch at pc+4.
- gnt withheld 3 cycles -> imem_req=1 with imem_addr constant for all 3 cycles; only one rvalid consumed.
- Redirect to 32'h0000_0100 while in WAIT -> DRAIN; the pending rdata (32'hDEADBEEF) never appears on instr; next imem_addr=32'h100.
- Redirect to 32'h0000_0102 -> fetch_fault=1, imem_req=0 and instr_valid=0 indefinitely; rst_n low for 1 cycle -> fault cleared, fetch restarts at RESET_PC.
- PC wrap: RESET_PC=32'hFFFF_FFFC, accept one instruction -> instr_pc_plus4=0 and next imem_addr=0.
